// File: rtl/waterfall_fb_ctrl_pkg.sv
// Shared types and helpers for the waterfall frame-buffer controller.
// Holds the controller state encoding, default geometry and the row-index wrap helper.
package waterfall_pkg;

  typedef enum logic [1:0] {
    StClear     = 2'd0,
    StVideo     = 2'd1,
    StWriteLine = 2'd2,
    StWaitBlank = 2'd3
  } state_e;

  localparam int unsigned DefHVisible = 320;
  localparam int unsigned DefVVisible = 240;

  // (a +/- b) mod v for operands already in [0, v): one conditional correction, no divider.
  function automatic int unsigned wrap_row(input int unsigned a, input int unsigned b,
                                           input int unsigned v, input logic sub);
    int unsigned r;
    if (sub) begin
      r = (a >= b) ? (a - b) : (a + v - b);
    end else begin
      r = a + b;
      if (r >= v) r = r - v;
    end
    return r;
  endfunction

endpackage

// File: rtl/waterfall_fb_ctrl_if.sv
// Video-timing, bin-BRAM and frame-buffer signals of the waterfall controller.
// The controller side uses the slave modport; the video/memory side uses master.
interface waterfall_fb_ctrl_if #(
  parameter int unsigned X_W       = 9,
  parameter int unsigned Y_W       = 8,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned FB_ADDR_W = 17,
  parameter int unsigned DIV_W     = 4
);
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic                 lower_blank;
  logic [DIV_W-1:0]     scroll_div;
  logic                 scroll_down;
  logic                 freeze;
  logic [1:0]           gain;
  logic                 clear_req;
  logic [PIX_W-1:0]     bin_rdata;
  logic [X_W-1:0]       bin_raddr;
  logic                 bin_ren;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [PIX_W-1:0]     fb_wdata;
  logic                 fb_we;
  logic [Y_W-1:0]       y_offset;
  logic                 busy;

  modport master (
    output x, y, lower_blank, scroll_div, scroll_down, freeze, gain, clear_req, bin_rdata,
    input  bin_raddr, bin_ren, fb_addr, fb_wdata, fb_we, y_offset, busy
  );

  modport slave (
    input  x, y, lower_blank, scroll_div, scroll_down, freeze, gain, clear_req, bin_rdata,
    output bin_raddr, bin_ren, fb_addr, fb_wdata, fb_we, y_offset, busy
  );
endinterface

// File: rtl/waterfall_fb_ctrl_wrap_row_addr.sv
// Registered frame-buffer address: row = (a +/- b) mod V, addr = row * H + col.
// Used once for the pixel read path and once for the line write path.
module wrap_row_addr
  import waterfall_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DefHVisible,
  parameter int unsigned V_VISIBLE = DefVVisible,
  parameter int unsigned X_W       = 9,
  parameter int unsigned Y_W       = 8,
  parameter int unsigned FB_ADDR_W = 17
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [Y_W-1:0]       a_i,
  input  logic [Y_W-1:0]       b_i,
  input  logic                 sub_i,
  input  logic [X_W-1:0]       col_i,
  output logic [FB_ADDR_W-1:0] addr_o
);
  logic [Y_W-1:0]       row;
  logic [FB_ADDR_W-1:0] addr_d, addr_q;

  assign row    = Y_W'(wrap_row(32'(a_i), 32'(b_i), V_VISIBLE, sub_i));
  assign addr_d = FB_ADDR_W'(32'(row) * H_VISIBLE + 32'(col_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) addr_q <= '0;
    else         addr_q <= addr_d;
  end

  assign addr_o = addr_q;
endmodule

// File: rtl/waterfall_fb_ctrl.sv
// Scrolling waterfall frame-buffer controller: pixel readout addressing, per-blank line copy
// from the bin BRAM with gain/saturation, scroll rate/direction, freeze and full clear.
module waterfall_fb_ctrl
  import waterfall_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DefHVisible,
  parameter int unsigned V_VISIBLE   = DefVVisible,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned FB_ADDR_W   = 17,
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned CLEAR_VALUE = 0
) (
  input logic                clk_i,
  input logic                rst_ni,
  waterfall_fb_ctrl_if.slave bus_io
);
  localparam logic [FB_ADDR_W-1:0] ClrLast = FB_ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [X_W-1:0]       BinLast = X_W'(H_VISIBLE - 1);

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     fc_q, fc_d;
  logic [Y_W-1:0]       yoff_q, yoff_d;
  logic [X_W-1:0]       bin_q, bin_d;
  logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d, clr_addr_q;
  logic                 pend_q, pend_d, dir_q, dir_d;
  logic                 lb_q, clr_wr_q, line_wr_q;
  logic                 blank_rise;
  logic [Y_W-1:0]       yoff_m1, yoff_p1;
  logic [Y_W-1:0]       rd_a, rd_b, wr_row;
  logic [FB_ADDR_W-1:0] rd_addr, wr_addr;
  logic [PIX_W+2:0]     shifted;
  logic [PIX_W-1:0]     sat_data;

  assign blank_rise = bus_io.lower_blank & ~lb_q;
  assign yoff_m1    = Y_W'(wrap_row(32'(yoff_q), 32'd1, V_VISIBLE, 1'b1));
  assign yoff_p1    = Y_W'(wrap_row(32'(yoff_q), 32'd1, V_VISIBLE, 1'b0));

  // Scroll-down reads r = (y_offset-1) - y; scroll-up reads r = y + y_offset.
  assign rd_a   = dir_q ? yoff_m1 : bus_io.y;
  assign rd_b   = dir_q ? bus_io.y : yoff_q;
  assign wr_row = dir_q ? yoff_m1 : yoff_q;

  wrap_row_addr #(
    .H_VISIBLE(H_VISIBLE), .V_VISIBLE(V_VISIBLE), .X_W(X_W), .Y_W(Y_W), .FB_ADDR_W(FB_ADDR_W)
  ) u_rd_addr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .a_i   (rd_a),
    .b_i   (rd_b),
    .sub_i (dir_q),
    .col_i (bus_io.x),
    .addr_o(rd_addr)
  );

  wrap_row_addr #(
    .H_VISIBLE(H_VISIBLE), .V_VISIBLE(V_VISIBLE), .X_W(X_W), .Y_W(Y_W), .FB_ADDR_W(FB_ADDR_W)
  ) u_wr_addr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .a_i   (wr_row),
    .b_i   ('0),
    .sub_i (1'b0),
    .col_i (bin_q),
    .addr_o(wr_addr)
  );

  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q;
    yoff_d    = yoff_q;
    bin_d     = bin_q;
    clr_cnt_d = clr_cnt_q;
    dir_d     = dir_q;
    pend_d    = pend_q | bus_io.clear_req;
    unique case (state_q)
      StClear: begin
        pend_d    = 1'b0;
        clr_cnt_d = clr_cnt_q + FB_ADDR_W'(1);
        if (clr_cnt_q == ClrLast) begin
          clr_cnt_d = '0;
          yoff_d    = '0;
          state_d   = StVideo;
        end
      end
      StVideo: begin
        if (blank_rise) begin
          dir_d = bus_io.scroll_down;
          if (pend_q) begin
            state_d = StClear;
          end else if (bus_io.freeze) begin
            state_d = StWaitBlank;
          end else if (fc_q == bus_io.scroll_div) begin
            fc_d    = '0;
            state_d = StWriteLine;
          end else begin
            fc_d    = fc_q + DIV_W'(1);
            state_d = StWaitBlank;
          end
        end
      end
      StWriteLine: begin
        bin_d = bin_q + X_W'(1);
        if (bin_q == BinLast) begin
          bin_d   = '0;
          yoff_d  = dir_q ? yoff_m1 : yoff_p1;
          state_d = StWaitBlank;
        end
      end
      StWaitBlank: begin
        if (!bus_io.lower_blank) state_d = StVideo;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StClear;
      fc_q       <= '0;
      yoff_q     <= '0;
      bin_q      <= '0;
      clr_cnt_q  <= '0;
      clr_addr_q <= '0;
      pend_q     <= 1'b0;
      dir_q      <= 1'b0;
      lb_q       <= 1'b0;
      clr_wr_q   <= 1'b0;
      line_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      yoff_q     <= yoff_d;
      bin_q      <= bin_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_addr_q <= clr_cnt_q;
      pend_q     <= pend_d;
      dir_q      <= dir_d;
      lb_q       <= bus_io.lower_blank;
      clr_wr_q   <= (state_q == StClear);
      line_wr_q  <= (state_q == StWriteLine);
    end
  end

  // Bin data arrives one cycle after the read, aligned with the registered write strobe.
  assign shifted  = {3'b000, bus_io.bin_rdata} << bus_io.gain;
  assign sat_data = (|shifted[PIX_W+2:PIX_W]) ? '1 : shifted[PIX_W-1:0];

  assign bus_io.bin_ren   = (state_q == StWriteLine);
  assign bus_io.bin_raddr = bin_q;
  assign bus_io.fb_we     = clr_wr_q | line_wr_q;
  assign bus_io.fb_addr   = line_wr_q ? wr_addr : (clr_wr_q ? clr_addr_q : rd_addr);
  assign bus_io.fb_wdata  = line_wr_q ? sat_data :
                            (clr_wr_q ? PIX_W'(CLEAR_VALUE) : '0);
  assign bus_io.y_offset  = yoff_q;
  assign bus_io.busy      = (state_q == StClear) || (state_q == StWriteLine);
endmodule

// File: tb/tb_waterfall_fb_ctrl.sv
// Scoreboard bench for waterfall_fb_ctrl at H=8, V=4: expected frame-buffer writes are queued
// by the stimulus and popped by a write monitor; state outputs are checked directly.
module tb_waterfall_fb_ctrl;
  localparam int H = 8;
  localparam int V = 4;

  logic clk;
  logic rst_n;
  logic [7:0] mem [8];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_addr[$];
  int exp_data[$];

  waterfall_fb_ctrl_if #(.X_W(4), .Y_W(3), .PIX_W(8), .FB_ADDR_W(5), .DIV_W(4)) bus ();

  waterfall_fb_ctrl #(
    .H_VISIBLE(H), .V_VISIBLE(V), .PIX_W(8), .X_W(4), .Y_W(3), .FB_ADDR_W(5), .DIV_W(4),
    .CLEAR_VALUE(0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bin BRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.bin_ren) bus.bin_rdata <= mem[bus.bin_raddr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.fb_we) begin
      if (exp_addr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0d, no write expected",
                 bus.fb_addr, bus.fb_wdata);
      end else begin
        check("wr_addr", int'(bus.fb_addr), exp_addr.pop_front());
        check("wr_data", int'(bus.fb_wdata), exp_data.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int row, input int g);
    int v;
    for (int k = 0; k < H; k++) begin
      v = int'(mem[k]) << g;
      exp_addr.push_back(k + row * H);
      exp_data.push_back(v > 255 ? 255 : v);
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < H * V; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(0);
    end
  endtask

  task automatic do_blank(input logic frz);
    bus.freeze      = frz;
    bus.lower_blank = 1'b1;
    tick(20);
    bus.lower_blank = 1'b0;
    bus.freeze      = 1'b0;
    tick(4);
  endtask

  task automatic read_chk(input string name, input int yy, input int xx, input int row);
    bus.y = 3'(yy);
    bus.x = 4'(xx);
    tick(1);
    check(name, int'(bus.fb_addr), xx + row * H);
  endtask

  initial begin
    int yexp [7];
    yexp = '{1, 1, 1, 2, 2, 2, 3};
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    rst_n           = 1'b0;
    bus.x           = '0;
    bus.y           = '0;
    bus.lower_blank = 1'b0;
    bus.scroll_div  = '0;
    bus.scroll_down = 1'b0;
    bus.freeze      = 1'b0;
    bus.gain        = 2'd0;
    bus.clear_req   = 1'b0;
    bus.bin_rdata   = '0;
    tick(3);
    check("rst_fb_we", int'(bus.fb_we), 0);
    check("rst_fb_addr", int'(bus.fb_addr), 0);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_y_offset", int'(bus.y_offset), 0);
    check("rst_bin_ren", int'(bus.bin_ren), 0);

    // Power-up clear: 32 writes of 0 to addresses 0..31.
    push_clear();
    rst_n = 1'b1;
    tick(2);
    check("clr_busy", int'(bus.busy), 1);
    tick(40);
    check("clr_done_busy", int'(bus.busy), 0);
    check("clr_done_yoff", int'(bus.y_offset), 0);
    check("clr_queue", exp_addr.size(), 0);

    // Four scrolls upward: rows 0,1,2,3, y_offset 1,2,3,0.
    for (int s = 0; s < 4; s++) begin
      push_line(s, 0);
      do_blank(1'b0);
      check("scroll_yoff", int'(bus.y_offset), (s + 1) % V);
      check("scroll_queue", exp_addr.size(), 0);
    end
    read_chk("rd_y3_yoff0", 3, 5, 3);
    read_chk("rd_y1_yoff0", 1, 2, 1);

    // Gain 2 with saturation: 0x50 and 0x40 clip to 0xFF, 0x3F becomes 0xFC.
    mem[0]   = 8'h50;
    mem[1]   = 8'h3F;
    mem[7]   = 8'h40;
    bus.gain = 2'd2;
    push_line(0, 2);
    check("gain_exp0", exp_data[0], 255);
    check("gain_exp1", exp_data[1], 252);
    do_blank(1'b0);
    check("gain_yoff", int'(bus.y_offset), 1);
    bus.gain = 2'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    read_chk("rd_wrap_y3_yoff1", 3, 4, 0);
    read_chk("rd_y2_yoff1", 2, 6, 3);

    // scroll_div=2, freeze at blank 2 holds the counter: writes land on blanks 4 and 7.
    bus.scroll_div = 4'd2;
    bus.freeze     = 1'b1;
    tick(3);
    bus.freeze     = 1'b0;
    tick(2);
    for (int b = 1; b <= 7; b++) begin
      if (b == 4) push_line(1, 0);
      if (b == 7) push_line(2, 0);
      do_blank(b == 2);
      check("div_yoff", int'(bus.y_offset), yexp[b-1]);
    end
    check("div_queue", exp_addr.size(), 0);

    // Mid-frame clear request takes effect at the next blank; a request during CLEAR is dropped.
    bus.clear_req = 1'b1;
    tick(1);
    bus.clear_req = 1'b0;
    tick(3);
    push_clear();
    bus.lower_blank = 1'b1;
    tick(5);
    check("clear_busy", int'(bus.busy), 1);
    bus.clear_req = 1'b1;
    tick(1);
    bus.clear_req = 1'b0;
    tick(40);
    bus.lower_blank = 1'b0;
    tick(4);
    check("clear_busy_done", int'(bus.busy), 0);
    check("clear_yoff", int'(bus.y_offset), 0);
    check("clear_queue", exp_addr.size(), 0);

    // Scroll down from y_offset 0: write row 3, y_offset 3, screen y=0 shows row 2.
    bus.scroll_div  = 4'd0;
    bus.scroll_down = 1'b1;
    push_line(3, 0);
    do_blank(1'b0);
    check("down_yoff", int'(bus.y_offset), 3);
    read_chk("rd_down_y0", 0, 1, 2);
    read_chk("rd_down_y2", 2, 0, 0);
    read_chk("rd_down_y3", 3, 7, 3);

    tick(4);
    check("final_queue", exp_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
